// File: rtl/multdiv_pkg.sv
// multdiv_pkg: state encodings and counter width shared by the multiply/divide unit
package multdiv_pkg;
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;
    localparam int MD_CNT_W = 6;
endpackage

// File: rtl/multdiv_if.sv
// multdiv_if: operand/start/result bundle between execute stage and multiply/divide unit
interface multdiv_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );
    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_counter.sv
// multdiv_counter: iteration counter, cleared on start, flags the final iteration
module multdiv_counter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic last
);
    logic [MD_CNT_W-1:0] count;
    assign last = count == MD_CNT_W'(WIDTH - 1);
    // count iterations 0..WIDTH-1, wrapping so the idle value is always 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= last ? '0 : count + MD_CNT_W'(1);
    end
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (shift-add) / divide (restoring) on magnitudes
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    multdiv_if.slave   bus
);
    md_state_t          state, state_d;
    logic               start_mul, start_div, start, busy, last;
    logic               is_div, neg;
    logic [WIDTH-1:0]   opnd, mag_a, mag_b, add_x, m_add, q_res;
    logic [2*WIDTH-1:0] prod, sh, p_res;
    logic [WIDTH:0]     sum;
    assign start_mul = bus.ctrl_MULT & ~bus.ctrl_DIV;
    assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign start     = start_mul | start_div;
    assign busy      = (state == MD_MUL) || (state == MD_DIV);
    assign mag_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign mag_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    // one adder serves both ops: add multiplicand into the high word, or trial-subtract the divisor
    assign sh    = {prod[2*WIDTH-2:0], 1'b0};
    assign add_x = is_div ? sh[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    assign m_add = (is_div || prod[0]) ? opnd : '0;
    assign sum   = is_div ? {1'b0, add_x} - {1'b0, m_add} : {1'b0, add_x} + {1'b0, m_add};
    assign p_res = neg ? -prod : prod;
    assign q_res = neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    multdiv_counter #(.WIDTH(WIDTH)) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (start),
        .en      (busy),
        .last    (last)
    );
    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= MD_IDLE;
        else state <= state_d;
    end
    // a valid start always wins, restarting even a busy unit; otherwise run to DONE then idle
    always_comb begin
        state_d = state;
        if (start) state_d = start_mul ? MD_MUL : MD_DIV;
        else if (busy && last) state_d = MD_DONE;
        else if (state == MD_DONE) state_d = MD_IDLE;
    end
    // latch magnitudes and result sign on start, then iterate one bit per cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prod   <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg    <= 1'b0;
        end else if (start) begin
            is_div <= start_div;
            neg    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            opnd   <= start_div ? mag_b : mag_a;
            prod   <= {{WIDTH{1'b0}}, start_div ? mag_a : mag_b};
        end else if (busy) begin
            prod <= is_div ? (sum[WIDTH] ? sh : {sum[WIDTH-1:0], sh[WIDTH-1:1], 1'b1})
                           : {sum, prod[WIDTH-1:1]};
        end
    end
    // sign-correct and publish the result with a one-cycle ready strobe; hold it otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
        end else begin
            bus.data_resultRDY <= state == MD_DONE;
            if (state == MD_DONE) begin
                bus.data_result    <= is_div ? (opnd == '0 ? '0 : q_res) : p_res[WIDTH-1:0];
                bus.data_exception <= is_div ? (opnd == '0 || (!neg && prod[WIDTH-1]))
                                             : p_res[2*WIDTH-1:WIDTH] != {WIDTH{p_res[WIDTH-1]}};
            end
        end
    end
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed vectors for the multiply/divide unit
module tb_multdiv_unit;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int k;
    multdiv_if #(.WIDTH(32)) bus ();
    multdiv_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT = m;
        bus.ctrl_DIV = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = 32'hDEAD_BEEF;
        bus.data_operandB = 32'h1234_5678;
    endtask
    task automatic wait_rdy(input int max, output int n);
        n = max + 1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY) begin
                n = i;
                break;
            end
        end
    endtask
    task automatic run_op(input string tag, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        int n;
        pulse(!d, d, a, b);
        wait_rdy(40, n);
        check({tag, "_lat"}, 64'(n), 64'd33);
        check({tag, "_res"}, 64'(bus.data_result), 64'(exp_res));
        check({tag, "_exc"}, 64'(bus.data_exception), 64'(exp_exc));
        @(negedge clock);
        check({tag, "_rdy_off"}, 64'(bus.data_resultRDY), 64'd0);
        check({tag, "_hold"}, 64'(bus.data_result), 64'(exp_res));
    endtask
    initial begin
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(negedge clock);
        check("rst_res", 64'(bus.data_result), 64'd0);
        check("rst_exc", 64'(bus.data_exception), 64'd0);
        check("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("mul_m6_m7", 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'd42, 1'b0);
        run_op("mul_max_2", 1'b0, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);
        run_op("div_by0", 1'b1, 32'd100, 32'd0, 32'd0, 1'b1);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        pulse(1'b1, 1'b0, 32'd5, 32'd5);
        repeat (9) @(negedge clock);
        pulse(1'b0, 1'b1, 32'd9, 32'd3);
        wait_rdy(40, k);
        check("abort_lat", 64'(k), 64'd33);
        check("abort_res", 64'(bus.data_result), 64'd3);
        check("abort_exc", 64'(bus.data_exception), 64'd0);
        wait_rdy(40, k);
        check("abort_no_2nd", 64'(k), 64'd41);
        pulse(1'b1, 1'b1, 32'd4, 32'd4);
        wait_rdy(40, k);
        check("both_no_rdy", 64'(k), 64'd41);
        check("both_hold", 64'(bus.data_result), 64'd3);
        pulse(1'b1, 1'b0, 32'd1000, 32'd1000);
        repeat (19) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rstmid_res", 64'(bus.data_result), 64'd0);
        check("rstmid_exc", 64'(bus.data_exception), 64'd0);
        check("rstmid_rdy", 64'(bus.data_resultRDY), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        wait_rdy(40, k);
        check("rstmid_no_rdy", 64'(k), 64'd41);
        run_op("mul_2_3", 1'b0, 32'd2, 32'd3, 32'd6, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
